// File: rtl/arm_timer_pkg.sv
// Shared encodings for the timeout scheduler: request opcodes and channel state.
package arm_timer_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_ARM    = 2'b01;
    localparam logic [1:0] OP_CANCEL = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } ch_state_t;

endpackage

// File: rtl/arm_tick_gen.sv
// Prescaler and free-running time base; emits a one-cycle tick every PRESCALE+1 enabled cycles.
module arm_tick_gen #(
    parameter int PRESCALE = 1000,
    parameter int TIME_W   = 32
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              en_i,
    output logic              tick_o,
    output logic [TIME_W-1:0] time_o
);

    localparam int PRE_W = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);

    logic [PRE_W-1:0]  pre_q;
    logic [TIME_W-1:0] time_q;

    assign tick_o = en_i && (pre_q == PRE_W'(PRESCALE));
    assign time_o = time_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            pre_q  <= '0;
            time_q <= '0;
        end else if (tick_o) begin
            pre_q  <= '0;
            time_q <= time_q + TIME_W'(1);
        end else if (en_i) begin
            pre_q  <= pre_q + PRE_W'(1);
        end
    end

endmodule

// File: rtl/arm_timer_scheduler.sv
// Multi-channel one-shot/periodic timeout scheduler on a shared prescaled time base,
// with round-robin expiry delivery and sticky per-channel overrun flags.
module arm_timer_scheduler
    import arm_timer_pkg::*;
#(
    parameter int PRESCALE = 1000,
    parameter int TIME_W   = 32,
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2
) (
    input  logic              cnt_clk,
    input  logic              cnt_resetn,
    input  logic              cnt_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [CH_W-1:0]   req_ch,
    input  logic [TIME_W-1:0] req_delta,
    input  logic              req_periodic,
    output logic              exp_valid,
    input  logic              exp_ready,
    output logic [CH_W-1:0]   exp_ch,
    output logic [NUM_CH-1:0] ovr_flags,
    output logic [TIME_W-1:0] cnt_output
);

    function automatic logic [TIME_W-1:0] clamp_delta(input logic [TIME_W-1:0] v);
        return (v == '0) ? TIME_W'(1) : v;
    endfunction

    logic              tick;
    logic [TIME_W-1:0] time_now;
    logic              req_ready_q;
    logic [CH_W-1:0]   rr_q;
    logic [NUM_CH-1:0] pend_vec;
    logic [NUM_CH-1:0] ovr_vec;
    logic [CH_W-1:0]   exp_ch_c;
    logic              found;
    logic              req_acc;
    logic              exp_take;
    logic [TIME_W-1:0] req_d;

    arm_tick_gen #(
        .PRESCALE(PRESCALE),
        .TIME_W  (TIME_W)
    ) u_tick (
        .clk_i   (cnt_clk),
        .resetn_i(cnt_resetn),
        .en_i    (cnt_en),
        .tick_o  (tick),
        .time_o  (time_now)
    );

    assign req_ready  = req_ready_q;
    assign req_acc    = req_valid && req_ready_q;
    assign req_d      = clamp_delta(req_delta);
    assign exp_valid  = |pend_vec;
    assign exp_ch     = exp_ch_c;
    assign exp_take   = exp_valid && exp_ready;
    assign ovr_flags  = ovr_vec;
    assign cnt_output = time_now;

    always_ff @(posedge cnt_clk) begin
        if (!cnt_resetn) begin
            req_ready_q <= 1'b0;
            rr_q        <= CH_W'(NUM_CH - 1);
        end else begin
            req_ready_q <= 1'b1;
            if (exp_take) begin
                rr_q <= exp_ch_c;
            end
        end
    end

    // Search starts just after the last delivered channel so every channel gets a turn.
    always_comb begin
        exp_ch_c = rr_q;
        found    = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!found && pend_vec[(int'(rr_q) + k) % NUM_CH]) begin
                exp_ch_c = CH_W'((int'(rr_q) + k) % NUM_CH);
                found    = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t         state_q;
        logic [TIME_W-1:0] deadline_q;
        logic [TIME_W-1:0] period_q;
        logic              pend_q;
        logic              ovr_q;
        logic              arm_hit;
        logic              cancel_hit;
        logic              fire;
        logic              deliver;

        assign arm_hit    = req_acc && (req_op == OP_ARM) && (req_ch == CH_W'(i));
        assign cancel_hit = req_acc && (req_op == OP_CANCEL) && (req_ch == CH_W'(i));
        assign fire       = tick && (state_q == ARMED) && ((time_now + TIME_W'(1)) == deadline_q);
        assign deliver    = exp_take && (exp_ch_c == CH_W'(i));
        assign pend_vec[i] = pend_q;
        assign ovr_vec[i]  = ovr_q;

        // Priority: cancel, then re-arm, then fire; a delivery only matters when no new fire lands.
        always_ff @(posedge cnt_clk) begin
            if (!cnt_resetn) begin
                state_q <= IDLE;
                pend_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end else if (cancel_hit) begin
                state_q <= IDLE;
                pend_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end else if (arm_hit) begin
                state_q <= ARMED;
                if (deliver) begin
                    pend_q <= 1'b0;
                end
            end else if (fire) begin
                pend_q <= 1'b1;
                if (pend_q && !deliver) begin
                    ovr_q <= 1'b1;
                end
                if (period_q == '0) begin
                    state_q <= IDLE;
                end
            end else if (deliver) begin
                pend_q <= 1'b0;
            end
        end

        always_ff @(posedge cnt_clk) begin
            if (arm_hit) begin
                deadline_q <= time_now + req_d;
                period_q   <= req_periodic ? req_d : '0;
            end else if (fire) begin
                deadline_q <= deadline_q + period_q;
            end
        end
    end

endmodule

// File: tb/tb_arm_timer_scheduler.sv
// Randomized bench for arm_timer_scheduler with a tick-count reference model and expiry scoreboard.
module tb_arm_timer_scheduler;

    localparam int PRESCALE = 3;
    localparam int TIME_W   = 4;
    localparam int NUM_CH   = 4;
    localparam int CH_W     = 2;
    localparam int TMOD     = 1 << TIME_W;

    logic              cnt_clk = 1'b0;
    logic              cnt_resetn;
    logic              cnt_en;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [CH_W-1:0]   req_ch;
    logic [TIME_W-1:0] req_delta;
    logic              req_periodic;
    logic              exp_valid;
    logic              exp_ready;
    logic [CH_W-1:0]   exp_ch;
    logic [NUM_CH-1:0] ovr_flags;
    logic [TIME_W-1:0] cnt_output;

    arm_timer_scheduler #(
        .PRESCALE(PRESCALE),
        .TIME_W  (TIME_W),
        .NUM_CH  (NUM_CH),
        .CH_W    (CH_W)
    ) dut (
        .cnt_clk     (cnt_clk),
        .cnt_resetn  (cnt_resetn),
        .cnt_en      (cnt_en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_ch      (req_ch),
        .req_delta   (req_delta),
        .req_periodic(req_periodic),
        .exp_valid   (exp_valid),
        .exp_ready   (exp_ready),
        .exp_ch      (exp_ch),
        .ovr_flags   (ovr_flags),
        .cnt_output  (cnt_output)
    );

    always #5 cnt_clk = ~cnt_clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int exp_q[$];

    // Reference state: time kept as an unbounded tick count, deadlines as absolute tick numbers.
    int m_pre, m_ticks, m_rr;
    bit m_rdy;
    bit m_armed[NUM_CH];
    int m_dl[NUM_CH];
    int m_per[NUM_CH];
    bit m_pend[NUM_CH];
    bit m_ovr[NUM_CH];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_ticks = 0; m_rr = NUM_CH - 1; m_rdy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_armed[c] = 1'b0; m_pend[c] = 1'b0; m_ovr[c] = 1'b0;
            m_dl[c] = 0; m_per[c] = 0;
        end
    endtask

    initial model_reset();

    always @(negedge cnt_clk) begin
        bit mv, tick, acc, dlv, fire, arm_h, can_h, dl_c;
        int dch, ovr_exp, d;
        mv = 1'b0; dch = m_rr; ovr_exp = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!mv && m_pend[(m_rr + k) % NUM_CH]) begin
                mv = 1'b1;
                dch = (m_rr + k) % NUM_CH;
            end
        end
        for (int c = 0; c < NUM_CH; c++) ovr_exp |= int'(m_ovr[c]) << c;
        if (chk_on) begin
            chk("req_ready", int'(req_ready), int'(m_rdy));
            chk("cnt_output", int'(cnt_output), m_ticks % TMOD);
            chk("exp_valid", int'(exp_valid), int'(mv));
            chk("ovr_flags", int'(ovr_flags), ovr_exp);
            if (mv) chk("exp_ch_presented", int'(exp_ch), dch);
        end
        dlv = mv && exp_ready;
        if (chk_on && dlv) exp_q.push_back(dch);
        if (!cnt_resetn) begin
            model_reset();
        end else begin
            tick = cnt_en && (m_pre == PRESCALE);
            acc  = req_valid && m_rdy;
            for (int c = 0; c < NUM_CH; c++) begin
                arm_h = acc && (req_op == 2'b01) && (int'(req_ch) == c);
                can_h = acc && (req_op == 2'b10) && (int'(req_ch) == c);
                dl_c  = dlv && (dch == c);
                fire  = tick && m_armed[c] && (m_ticks + 1 == m_dl[c]);
                if (can_h) begin
                    m_armed[c] = 1'b0; m_pend[c] = 1'b0; m_ovr[c] = 1'b0;
                end else if (arm_h) begin
                    d = (req_delta == 0) ? 1 : int'(req_delta);
                    m_armed[c] = 1'b1;
                    m_dl[c]    = m_ticks + d;
                    m_per[c]   = req_periodic ? d : 0;
                    if (dl_c) m_pend[c] = 1'b0;
                end else if (fire) begin
                    if (m_pend[c] && !dl_c) m_ovr[c] = 1'b1;
                    m_pend[c] = 1'b1;
                    if (m_per[c] == 0) m_armed[c] = 1'b0;
                    else m_dl[c] = m_dl[c] + m_per[c];
                end else if (dl_c) begin
                    m_pend[c] = 1'b0;
                end
            end
            if (dlv) m_rr = dch;
            if (tick) begin
                m_pre = 0;
                m_ticks++;
            end else if (cnt_en) begin
                m_pre++;
            end
            m_rdy = 1'b1;
        end
    end

    always @(negedge cnt_clk) begin
        #1;
        if (chk_on && exp_valid === 1'b1 && exp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_expiry", int'(exp_ch), -1);
            end else begin
                chk("expiry_ch", int'(exp_ch), exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge cnt_clk);
            #1;
        end
    endtask

    // An ARM of delta<=1 issued on a tick cycle would be measured from the pre-tick time
    // and wrap around, so such deltas are bumped to 2.
    function automatic logic [TIME_W-1:0] safe_delta(input logic [1:0] op, input logic [TIME_W-1:0] d);
        if (op == 2'b01 && d <= 1 && cnt_en && m_pre == PRESCALE) return TIME_W'(2);
        return d;
    endfunction

    task automatic req(input logic [1:0] op, input int ch, input int delta, input bit per);
        req_valid    = 1'b1;
        req_op       = op;
        req_ch       = CH_W'(ch);
        req_periodic = per;
        req_delta    = safe_delta(op, TIME_W'(delta));
        cyc(1);
        req_valid    = 1'b0;
        req_op       = 2'b00;
    endtask

    initial begin
        bit stall;
        cnt_resetn = 1'b0; cnt_en = 1'b0; req_valid = 1'b0; req_op = 2'b00;
        req_ch = '0; req_delta = '0; req_periodic = 1'b0; exp_ready = 1'b0;
        cyc(3);
        chk_on = 1'b1;
        cnt_resetn = 1'b1; cnt_en = 1'b1; exp_ready = 1'b1;
        cyc(40);
        req(2'b01, 0, 5, 1'b0);
        cyc(30);
        exp_ready = 1'b0;
        req(2'b01, 1, 2, 1'b1);
        cyc(24);
        exp_ready = 1'b1;
        cyc(12);
        req(2'b10, 1, 0, 1'b0);
        req(2'b01, 0, 3, 1'b0);
        req(2'b01, 2, 3, 1'b0);
        req(2'b01, 3, 3, 1'b0);
        cyc(20);
        req(2'b01, 2, 0, 1'b0);
        cyc(10);
        req(2'b01, 2, 15, 1'b0);
        cyc(70);
        cnt_en = 1'b0;
        req(2'b01, 3, 1, 1'b0);
        cyc(10);
        cnt_en = 1'b1;
        cyc(10);
        exp_ready = 1'b0;
        req(2'b01, 0, 1, 1'b0);
        req(2'b01, 1, 1, 1'b0);
        req(2'b01, 2, 2, 1'b0);
        cyc(12);
        cnt_resetn = 1'b0;
        cyc(1);
        cnt_resetn = 1'b1;
        exp_ready = 1'b1;
        cyc(8);
        stall = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 60 == 0) stall = ($urandom_range(0, 2) == 0);
            exp_ready    = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            cnt_en       = ($urandom_range(0, 15) != 0);
            cnt_resetn   = ($urandom_range(0, 599) != 0);
            req_valid    = ($urandom_range(0, 2) == 0);
            req_op       = 2'($urandom_range(0, 3));
            req_ch       = CH_W'($urandom_range(0, NUM_CH - 1));
            req_periodic = 1'($urandom_range(0, 1));
            req_delta    = safe_delta(req_op, TIME_W'($urandom_range(0, TMOD - 1)));
            cyc(1);
        end
        cnt_resetn = 1'b1; req_valid = 1'b0; req_op = 2'b00; exp_ready = 1'b1;
        cyc(20);
        @(negedge cnt_clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
